// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared types and sizing helper for the data-memory load/store unit
package lsu_pkg;

  // Access size as encoded on the request port
  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } mem_size_t;

  // Sequencer states; sub-word stores walk READ -> WAIT -> WRITE
  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    RESP
  } lsu_state_t;

  localparam int DMEM_WORDS_DEFAULT = 2048;

  // Width of the word index needed to address a memory of the given depth
  function automatic int word_aw(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request, response and memory-port bundle of the load/store unit
interface dmem_lsu_if;

  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_req_store;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;

  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_misaligned;

  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_write_data;
  logic        o_mem_write_enable;
  logic [31:0] i_mem_read_data;

  // The load/store unit itself
  modport slave (
    input  i_req_valid, i_req_addr, i_req_wdata, i_req_store, i_req_size, i_req_unsigned,
    input  i_mem_read_data,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_misaligned,
    output o_mem_addr, o_mem_write_data, o_mem_write_enable
  );

  // The surrounding execute stage and data memory
  modport master (
    output i_req_valid, i_req_addr, i_req_wdata, i_req_store, i_req_size, i_req_unsigned,
    output i_mem_read_data,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_misaligned,
    input  o_mem_addr, o_mem_write_data, o_mem_write_enable
  );

endinterface

// File: rtl/dmem_lsu_align.sv
// rtl/dmem_lsu_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  lane,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  input  logic [31:0] st_old,
  input  logic [31:0] st_wdata,
  output logic [31:0] ld_result,
  output logic [31:0] st_result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane of the loaded word and extend it to 32 bits
  always_comb begin
    byte_sel  = ld_word[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? ld_word[31:16] : ld_word[15:0];
    ld_result = ld_word;
    case (size)
      SIZE_B:  ld_result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_H:  ld_result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: ld_result = ld_word;
    endcase
  end

  // Replace the addressed byte/half of the old word; word stores take wdata whole
  always_comb begin
    st_result = st_old;
    case (size)
      SIZE_B: st_result[{lane, 3'b000} +: 8] = st_wdata[7:0];
      SIZE_H: begin
        if (lane[1]) st_result[31:16] = st_wdata[15:0];
        else         st_result[15:0]  = st_wdata[15:0];
      end
      SIZE_W:  st_result = st_wdata;
      default: st_result = st_old;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-op load/store sequencer in front of the word-only data memory
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = DMEM_WORDS_DEFAULT
) (
  input logic       i_clk,
  input logic       i_rst,
  dmem_lsu_if.slave bus
);

  localparam int WORD_AW = word_aw(DMEM_WORDS);

  lsu_state_t  state_q;
  lsu_state_t  state_d;

  logic [31:0] mem_addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  lane_q;
  logic        store_q;
  logic        unsigned_q;
  logic        mis_q;
  mem_size_t   size_q;

  mem_size_t   req_size;
  logic        req_mis;
  logic        accept;
  logic [31:0] ld_result;
  logic [31:0] st_result;

  // Address bits above the memory span simply wrap
  logic        unused_addr_bits;
  assign unused_addr_bits = ^bus.i_req_addr[31:WORD_AW+2];

  assign req_size = mem_size_t'(bus.i_req_size);
  assign accept   = bus.i_req_valid && (state_q == IDLE);

  // Classify the incoming request's alignment against its size
  always_comb begin
    req_mis = 1'b0;
    case (req_size)
      SIZE_H:  req_mis = bus.i_req_addr[0];
      SIZE_W:  req_mis = (bus.i_req_addr[1:0] != 2'b00);
      SIZE_X:  req_mis = 1'b1;
      default: req_mis = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latch the accepted request and capture the memory word during WAIT
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_addr_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      lane_q     <= '0;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      mis_q      <= 1'b0;
      size_q     <= SIZE_B;
    end else begin
      if (accept) begin
        mem_addr_q <= {{(32-WORD_AW){1'b0}}, bus.i_req_addr[WORD_AW+1:2]};
        wdata_q    <= bus.i_req_wdata;
        lane_q     <= bus.i_req_addr[1:0];
        store_q    <= bus.i_req_store;
        unsigned_q <= bus.i_req_unsigned;
        mis_q      <= req_mis;
        size_q     <= req_size;
      end
      if (state_q == WAIT) rdata_q <= bus.i_mem_read_data;
    end
  end

  lsu_align u_align (
    .ld_word     (rdata_q),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .st_old      (rdata_q),
    .st_wdata    (wdata_q),
    .ld_result   (ld_result),
    .st_result   (st_result)
  );

  // Next state and port drive; write and response are suppressed under reset
  always_comb begin
    state_d                = state_q;
    bus.o_req_ready        = 1'b0;
    bus.o_mem_write_enable = 1'b0;
    bus.o_mem_write_data   = '0;
    bus.o_resp_valid       = 1'b0;
    bus.o_resp_rdata       = '0;
    bus.o_resp_misaligned  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.o_req_ready = 1'b1;
        if (bus.i_req_valid) begin
          if (req_mis)                                    state_d = RESP;
          else if (bus.i_req_store && req_size == SIZE_W) state_d = WRITE;
          else                                            state_d = READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: state_d = store_q ? WRITE : RESP;
      WRITE: begin
        bus.o_mem_write_enable = ~i_rst;
        bus.o_mem_write_data   = i_rst ? 32'd0 : st_result;
        state_d                = RESP;
      end
      RESP: begin
        bus.o_resp_valid      = ~i_rst;
        bus.o_resp_misaligned = mis_q & ~i_rst;
        bus.o_resp_rdata      = (store_q || mis_q || i_rst) ? 32'd0 : ld_result;
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_mem_addr = mem_addr_q;

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit directly upstream of the parallel data memory. It accepts one memory op at a time from the execute stage and converts byte addresses to word indices. Sub-word stores become read-modify-write sequences, because the memory port is word-only. Load data is extracted and sign- or zero-extended, and the unit returns a single-cycle response or a misalignment flag.

Parameters:
DMEM_WORDS, 2048, number of 32-bit words in the data memory.
WORD_AW, $clog2(DMEM_WORDS) = 11, width of the word index carried on o_mem_addr.

Ports:
i_clk  input  1  clock; all state updates on its rising edge.
i_rst  input  1  synchronous, active-high reset.
i_req_valid  input  1  request present.
o_req_ready  output  1  unit idle; a request is accepted when i_req_valid & o_req_ready.
i_req_addr  input  32  byte address.
i_req_wdata  input  32  store data; low byte/half used for sub-word stores.
i_req_store  input  1  1=store, 0=load.
i_req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
i_req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend; ignored for stores.
o_resp_valid  output  1  one-cycle completion pulse; no backpressure.
o_resp_rdata  output  32  load result; 0 for stores and faults.
o_resp_misaligned  output  1  qualified by o_resp_valid; access rejected.
o_mem_addr  output  32  word index, zero-extended from i_req_addr[WORD_AW+1:2].
o_mem_write_data  output  32  word to write.
o_mem_write_enable  output  1  1=write this cycle, 0=read.
i_mem_read_data  input  32  read data, valid the cycle after the address is presented with write_enable=0.

Behaviour:
- Reset (synchronous):
  - FSM goes to IDLE.
  - o_resp_valid=0, o_resp_rdata=0, o_resp_misaligned=0.
  - o_mem_write_enable=0, o_mem_addr=0, o_mem_write_data=0.
  - o_req_ready=1 the cycle after reset deasserts.
- Reset mid-operation abandons the op: no write is issued in or after the reset cycle, and no response is produced.
- FSM states:
  - IDLE: o_req_ready=1 only in this state. On accept, latch addr, wdata, store, size and unsigned.
    - Misaligned → RESP.
    - Word store → WRITE.
    - Otherwise → READ.
  - READ: drive o_mem_addr, write_enable=0 → WAIT.
  - WAIT: capture i_mem_read_data into a data register.
    - Load → RESP.
    - Sub-word store → WRITE.
  - WRITE: write_enable=1. Write data is either the merged word (captured word with the addressed byte/half replaced) or the latched wdata for word stores → RESP.
  - RESP: o_resp_valid=1 for exactly one cycle → IDLE.
- Latency, with accept in cycle 0, measured to the o_resp_valid cycle:
  - Misaligned: cycle 1.
  - Word store: cycle 2.
  - Load: cycle 3.
  - Sub-word store: cycle 4.
- Throughput is one op per latency+1 cycles, because ready is low from the accept cycle's successor until IDLE.
- o_mem_addr is held constant from READ through WRITE. write_enable is 1 only in the WRITE state.
- Misaligned means any of: half with addr[0]=1; word with addr[1:0]≠0; size=11. A misaligned op makes no memory access, and o_resp_rdata=0.
- Byte lanes are little-endian:
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (upper half when 1).
- Load extension:
  - Byte: sign/zero-extend bit 7 of the selected lane.
  - Half: sign/zero-extend bit 15 of the selected half.
  - Word: passed through; the unsigned bit is ignored.
- Address bits above WORD_AW+1 are ignored, so addresses wrap modulo DMEM_WORDS*4; no fault is raised.
- Requests arriving while busy are not accepted; the requester holds them.

Decomposition:
- Package lsu_pkg holds:
  - mem_size_t enum: SIZE_B, SIZE_H, SIZE_W, SIZE_X.
  - lsu_state_t enum: IDLE, READ, WAIT, WRITE, RESP.
  - WORD_AW derivation helper.
- Sub-module lsu_align is purely combinational and has two functions:
  - load extract/extend: word, lane, size, unsigned → result.
  - store merge: old word, wdata, lane, size → new word.
- dmem_lsu holds the FSM, the latch registers and the memory port drive.

Test Plan:
- Preload word 5 = 0x8899AABB:
  - lb 0x17 → resp cycle 3, rdata 0xFFFFFF88.
  - lbu 0x17 → 0x00000088.
  - lh 0x16 → 0xFFFF8899.
  - lhu 0x14 → 0x0000AABB.
- sb 0x15 with wdata 0x12345677 over word 5 = 0x8899AABB:
  - READ cycle 1, write_enable=1 only in cycle 3 with data 0x889977BB at o_mem_addr=5.
  - resp cycle 4.
- sw 0x20 with wdata 0xDEADBEEF: single write cycle 1 to addr 8; resp cycle 2; a following lw 0x20 returns 0xDEADBEEF.
- Misalignment, each with zero memory writes:
  - lw 0x16 → resp cycle 1, misaligned=1, rdata=0.
  - sh 0x13 → misaligned=1.
  - size=11 → misaligned=1.
- Assert i_rst during WAIT of sh 0x14 → write_enable never 1, o_resp_valid stays 0, ready=1 the cycle after reset.
- Hold i_req_valid high with two queued loads → ready=0 cycles 1–3; second op accepted cycle 4, its resp at cycle 7; addr 0x1FFC+0x2000 wraps to word 2047.
